// File: rtl/pg_sleep_ctrl.sv
// Power-guard sequencer for the PG_BUS enable line: counts idle OSCTIMER ticks,
// drops the bus guard enable, and runs a timed wake-up back to ACTIVE.
module pg_sleep_ctrl #(
    parameter int IDLE_TICKS  = 4,
    parameter int WAKE_CYCLES = 3,
    parameter int CNT_W       = 8
) (
    input  logic             osc_clk,
    input  logic             rst,
    input  logic             tmr_clk_in,
    input  logic             activity,
    input  logic             force_sleep,
    input  logic             wake,
    output logic             pg_en,
    output logic             bus_ready,
    output logic             tmr_rst,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] sleep_count
);

    // Out-of-range parameters cannot be represented by the CNT_W-bit counters.
    if (IDLE_TICKS < 1 || IDLE_TICKS > (2 ** CNT_W) - 1) begin : g_bad_idle_ticks
        $error("pg_sleep_ctrl: IDLE_TICKS=%0d outside 1..2^CNT_W-1", IDLE_TICKS);
    end
    if (WAKE_CYCLES < 1 || WAKE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_wake_cycles
        $error("pg_sleep_ctrl: WAKE_CYCLES=%0d outside 1..2^CNT_W-1", WAKE_CYCLES);
    end

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_GUARD     = 2'd2,
        ST_WAKE      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TICKS - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] idle_cnt_q;
    logic [CNT_W-1:0] idle_cnt_d;
    logic [CNT_W-1:0] wake_cnt_q;
    logic [CNT_W-1:0] wake_cnt_d;
    logic [CNT_W-1:0] sleep_cnt_d;
    logic             tmr_rst_d;
    logic             sync1_q;
    logic             sync2_q;
    logic             sync3_q;
    logic             tick;

    // Two synchroniser flops plus one history flop for the rising-edge detect.
    always_ff @(posedge osc_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= tmr_clk_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign tick = sync2_q & ~sync3_q;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        tmr_rst_d  = 1'b0;
        unique case (state_q)
            ST_ACTIVE: begin
                if (wake) begin
                    state_d = ST_ACTIVE;
                end else if (force_sleep) begin
                    state_d = ST_GUARD;
                end else if (!activity) begin
                    state_d    = ST_IDLE_WAIT;
                    idle_cnt_d = '0;
                    tmr_rst_d  = 1'b1;
                end
            end
            ST_IDLE_WAIT: begin
                if (wake || activity) begin
                    state_d    = ST_ACTIVE;
                    idle_cnt_d = '0;
                end else if (force_sleep) begin
                    state_d = ST_GUARD;
                end else if (tick) begin
                    idle_cnt_d = idle_cnt_q + CNT_ONE;
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (wake || activity) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                wake_cnt_d = wake_cnt_q + CNT_ONE;
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // Sleep events are counted on the transition into GUARD and saturate.
    always_comb begin
        sleep_cnt_d = sleep_count;
        if (state_d == ST_GUARD && state_q != ST_GUARD && sleep_count != '1) begin
            sleep_cnt_d = sleep_count + CNT_ONE;
        end
    end

    always_ff @(posedge osc_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACTIVE;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            sleep_count <= '0;
            pg_en       <= 1'b1;
            bus_ready   <= 1'b1;
            tmr_rst     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            sleep_count <= sleep_cnt_d;
            pg_en       <= (state_d != ST_GUARD);
            bus_ready   <= (state_d == ST_ACTIVE) || (state_d == ST_IDLE_WAIT);
            tmr_rst     <= tmr_rst_d;
        end
    end

    assign state = state_q;

endmodule
